// File: rtl/crossbar_rr_arbiter.sv
// Purpose: per-destination round-robin arbiter for a NODES x NODES packet crossbar.
// Latency: pop is combinational in cycle t; grant_valid/grant_src are registered (t+1).
// Backpressure: out_ready[d]==0 blocks grants/pops for d and holds ptr[d].
// Optional: define XBAR_ARB_STATS_EN to add saturating per-destination grant counters.
`ifndef NUMNODES
`define NUMNODES 4
`endif

module crossbar_rr_arbiter #(
  parameter int NODES  = `NUMNODES,
  parameter int DEST_W = 8,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NODES)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [NODES-1:0]        req_valid,
  input  logic [NODES*DEST_W-1:0] req_dest,
  input  logic [NODES-1:0]        out_ready,
  output logic [NODES-1:0]        pop,
  output logic [NODES-1:0]        grant_valid,
  output logic [NODES*SEL_W-1:0]  grant_src,
`ifdef XBAR_ARB_STATS_EN
  output logic [NODES*CNT_W-1:0]  grant_count,
`endif
  output logic                    err_dest
);

  logic [SEL_W-1:0] ptr     [NODES];
  logic [SEL_W-1:0] src_q   [NODES];
  logic [SEL_W-1:0] win_idx [NODES];
  logic [NODES-1:0] win_vld;
  logic [NODES-1:0] elig    [NODES];  // elig[d][s]
  logic [NODES-1:0] bad_req;
  logic [SEL_W:0]   scan_idx;

  // Eligibility matrix and out-of-range destination detection per source.
  always_comb begin
    bad_req = '0;
    for (int d = 0; d < NODES; d++) elig[d] = '0;
    for (int s = 0; s < NODES; s++) begin
      if (req_valid[s]) begin
        if (req_dest[s*DEST_W +: DEST_W] >= DEST_W'(NODES)) begin
          bad_req[s] = 1'b1;
        end else begin
          for (int d = 0; d < NODES; d++) begin
            if (req_dest[s*DEST_W +: DEST_W] == DEST_W'(d) && out_ready[d])
              elig[d][s] = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin scan for each destination starting at its priority pointer.
  always_comb begin
    win_vld  = '0;
    scan_idx = '0;
    for (int d = 0; d < NODES; d++) begin
      win_idx[d] = '0;
      for (int k = 0; k < NODES; k++) begin
        scan_idx = {1'b0, ptr[d]} + (SEL_W+1)'(k);
        if (scan_idx >= (SEL_W+1)'(NODES)) scan_idx = scan_idx - (SEL_W+1)'(NODES);
        if (!win_vld[d] && elig[d][scan_idx[SEL_W-1:0]]) begin
          win_vld[d] = 1'b1;
          win_idx[d] = scan_idx[SEL_W-1:0];
        end
      end
    end
  end

  // A source pops when it wins its (single) destination; suppressed during reset.
  always_comb begin
    pop = '0;
    for (int d = 0; d < NODES; d++) begin
      for (int s = 0; s < NODES; s++) begin
        if (win_vld[d] && win_idx[d] == SEL_W'(s)) pop[s] = 1'b1;
      end
    end
    if (!rst_l) pop = '0;
  end

  // Pointer advance past the winner, registered grant info and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      grant_valid <= '0;
      err_dest    <= 1'b0;
      for (int d = 0; d < NODES; d++) begin
        ptr[d]   <= '0;
        src_q[d] <= '0;
      end
    end else begin
      grant_valid <= win_vld;
      if (|bad_req) err_dest <= 1'b1;
      for (int d = 0; d < NODES; d++) begin
        if (win_vld[d]) begin
          ptr[d]   <= (win_idx[d] == SEL_W'(NODES-1)) ? '0 : win_idx[d] + SEL_W'(1);
          src_q[d] <= win_idx[d];
        end
      end
    end
  end

  // Flatten per-destination source select onto the output bus.
  always_comb begin
    for (int d = 0; d < NODES; d++) grant_src[d*SEL_W +: SEL_W] = src_q[d];
  end

`ifdef XBAR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NODES];

  // Saturating count of cycles each destination shows grant_valid.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int d = 0; d < NODES; d++) cnt[d] <= '0;
    end else begin
      for (int d = 0; d < NODES; d++) begin
        if (grant_valid[d] && cnt[d] != {CNT_W{1'b1}}) cnt[d] <= cnt[d] + CNT_W'(1);
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int d = 0; d < NODES; d++) grant_count[d*CNT_W +: CNT_W] = cnt[d];
  end
`endif

endmodule

// File: tb/tb_crossbar_rr_arbiter.sv
// Directed bench for crossbar_rr_arbiter with NODES=4, DEST_W=8, CNT_W=4.
// Table-driven vectors cover reset, single grant, rotation, backpressure, bad dest.
// Hand sequences cover mid-stream reset, boundary dest id and counter saturation.
module tb_crossbar_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [3:0]  req_valid;
  logic [31:0] req_dest;
  logic [3:0]  out_ready;
  logic [3:0]  pop;
  logic [3:0]  grant_valid;
  logic [7:0]  grant_src;
  logic        err_dest;
`ifdef XBAR_ARB_STATS_EN
  logic [15:0] grant_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  crossbar_rr_arbiter #(.NODES(4), .DEST_W(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_valid   (req_valid),
    .req_dest    (req_dest),
    .out_ready   (out_ready),
    .pop         (pop),
    .grant_valid (grant_valid),
    .grant_src   (grant_src),
`ifdef XBAR_ARB_STATS_EN
    .grant_count (grant_count),
`endif
    .err_dest    (err_dest)
  );

  typedef struct {
    logic        rst_l;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  ordy;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_gv;
    logic [7:0]  exp_gs;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic [31:0] rd,
                       input logic [3:0] ordy);
    rst_l = r; req_valid = rv; req_dest = rd; out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D_ALL0 = 32'h0000_0000;
  localparam logic [31:0] D_T2   = 32'h0001_0000;  // src2 -> dest1
  localparam logic [31:0] D_T5   = 32'h0501_0200;  // s0->0, s1->2, s2->1, s3->5 (bad)

  initial begin
    // rst_l rv    dest    ordy  pop     gv      gsrc   err
    tbl[0]  = '{1'b0, 4'hF, D_ALL0, 4'hF, 4'b0000, 4'b0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, D_ALL0, 4'hF, 4'b0000, 4'b0000, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, D_T2, 4'hF, 4'b0100, 4'b0010, 8'h08, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0001, 4'b0001, 8'h08, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0010, 4'b0001, 8'h09, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0100, 4'b0001, 8'h0A, 1'b0};
    tbl[6]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b1000, 4'b0001, 8'h0B, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0001, 4'b0001, 8'h08, 1'b0};
    tbl[8]  = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0010, 4'b0001, 8'h09, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, D_ALL0, 4'hE, 4'b0000, 4'b0000, 8'h09, 1'b0};
    tbl[10] = '{1'b1, 4'hF, D_ALL0, 4'hE, 4'b0000, 4'b0000, 8'h09, 1'b0};
    tbl[11] = '{1'b1, 4'hF, D_ALL0, 4'hE, 4'b0000, 4'b0000, 8'h09, 1'b0};
    tbl[12] = '{1'b1, 4'hF, D_ALL0, 4'hF, 4'b0100, 4'b0001, 8'h0A, 1'b0};
    tbl[13] = '{1'b1, 4'hF, D_T5,   4'hF, 4'b0111, 4'b0111, 8'h18, 1'b1};
    tbl[14] = '{1'b1, 4'b1000, D_T5, 4'hF, 4'b0000, 4'b0000, 8'h18, 1'b1};
    tbl[15] = '{1'b1, 4'b1001, D_T5, 4'hF, 4'b0001, 4'b0001, 8'h18, 1'b1};

    drive(1'b0, 4'hF, D_ALL0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst_l, tbl[i].rv, tbl[i].rd, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d pop", i), {28'h0, pop}, {28'h0, tbl[i].exp_pop});
      tick();
      chk($sformatf("v%0d grant_valid", i), {28'h0, grant_valid}, {28'h0, tbl[i].exp_gv});
      chk($sformatf("v%0d grant_src", i), {24'h0, grant_src}, {24'h0, tbl[i].exp_gs});
      chk($sformatf("v%0d err_dest", i), {31'h0, err_dest}, {31'h0, tbl[i].exp_err});
    end

    // Reset clears the sticky error and registers.
    drive(1'b0, 4'h0, D_ALL0, 4'hF);
    tick();
    chk("rst err_dest", {31'h0, err_dest}, 32'h0);
    chk("rst grant_src", {24'h0, grant_src}, 32'h0);

    // Mid-stream reset: two grants to dest0, then reset while all still requesting.
    drive(1'b1, 4'hF, D_ALL0, 4'hF);
    tick();
    chk("mid g0", {24'h0, grant_src}, 32'h00);
    tick();
    chk("mid g1", {24'h0, grant_src}, 32'h01);
    drive(1'b0, 4'hF, D_ALL0, 4'hF);
    #1;
    chk("mid rst pop", {28'h0, pop}, 32'h0);
    tick();
    chk("mid rst gv", {28'h0, grant_valid}, 32'h0);
    chk("mid rst gsrc", {24'h0, grant_src}, 32'h0);
    drive(1'b1, 4'hF, D_ALL0, 4'hF);
    #1;
    chk("post rst pop", {28'h0, pop}, 32'h1);
    tick();
    chk("post rst gv", {28'h0, grant_valid}, 32'h1);
    chk("post rst gsrc", {24'h0, grant_src}, 32'h00);

    // dest == NODES is out of range: never popped, flags error.
    drive(1'b1, 4'b1000, 32'h0400_0000, 4'hF);
    #1;
    chk("dest4 pop", {28'h0, pop}, 32'h0);
    tick();
    chk("dest4 err", {31'h0, err_dest}, 32'h1);
    chk("dest4 gv", {28'h0, grant_valid}, 32'h0);

`ifdef XBAR_ARB_STATS_EN
    // Saturation: 20 grants to dest 2 on a 4-bit counter.
    drive(1'b0, 4'h0, D_ALL0, 4'hF);
    tick();
    chk("cnt rst", {16'h0, grant_count}, 32'h0);
    drive(1'b1, 4'b0001, 32'h0000_0002, 4'hF);
    for (int i = 0; i < 20; i++) tick();
    drive(1'b1, 4'h0, D_ALL0, 4'hF);
    tick();
    tick();
    chk("cnt dest2 sat", {28'h0, grant_count[11:8]}, 32'hF);
    chk("cnt dest0", {28'h0, grant_count[3:0]}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
